// File: rtl/cla_slice_sequencer.sv
// Streams a WIDTH-bit add through a 4-bit registered CLA, LSB slice first; result valid N*(ADD_LAT+1) cycles after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module cla_slice_sequencer #(
    parameter int WIDTH   = 16,
    parameter int ADD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [WW-1:0] W_LAST = WW'(ADD_LAT);

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("cla_slice_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end
    if (ADD_LAT < 1) begin : g_bad_lat
        $error("cla_slice_sequencer: ADD_LAT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, next_state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_next;
    logic [WW-1:0]   wait_cnt;
    logic            sample;
    logic            last;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        sample     = 1'b0;
        last       = (k == K_LAST);
        k_next     = k + KW'(1);
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) next_state = RUN;
            end
            RUN: begin
                // The adder output has settled ADD_LAT edges after add_* changed; take it on the next edge.
                sample = (wait_cnt == W_LAST);
                if (sample && last) next_state = DONE;
            end
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            k         <= '0;
            wait_cnt  <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            add_a     <= 4'h0;
            add_b     <= 4'h0;
            add_cin   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        k        <= '0;
                        wait_cnt <= '0;
                        add_a    <= op_a[3:0];
                        add_b    <= op_b[3:0];
                        add_cin  <= op_cin;
                    end
                end
                RUN: begin
                    if (sample) begin
                        sum[4*k +: 4] <= add_s;
                        wait_cnt      <= '0;
                        if (last) begin
                            cout      <= add_cout;
                            out_valid <= 1'b1;
                            add_a     <= 4'h0;
                            add_b     <= 4'h0;
                            add_cin   <= 1'b0;
                        end else begin
                            // add_cin doubles as the running carry between slices.
                            k       <= k_next;
                            add_a   <= a_q[4*k_next +: 4];
                            add_b   <= b_q[4*k_next +: 4];
                            add_cin <= add_cout;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Bench for cla_slice_sequencer: WIDTH=16 and WIDTH=4 instances, each driving a two-stage registered 4-bit adder model.
module tb_cla_slice_sequencer;
    localparam int W   = 16;
    localparam int LAT = 2;
    localparam int N   = W / 4;
    localparam int L   = N * (LAT + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, op_cin, out_valid, out_ready, cout;
    logic [W-1:0] op_a, op_b, sum;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;

    logic         s_in_valid, s_in_ready, s_op_cin, s_out_valid, s_out_ready, s_cout;
    logic [3:0]   s_op_a, s_op_b, s_sum;
    logic [3:0]   s_add_a, s_add_b, s_add_s;
    logic         s_add_cin, s_add_cout;

    int errors = 0;
    int checks = 0;

    cla_slice_sequencer #(.WIDTH(W), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .add_a(add_a),
        .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
    );

    cla_slice_sequencer #(.WIDTH(4), .ADD_LAT(LAT)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op_a(s_op_a), .op_b(s_op_b), .op_cin(s_op_cin), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout), .add_a(s_add_a),
        .add_b(s_add_b), .add_cin(s_add_cin), .add_s(s_add_s), .add_cout(s_add_cout)
    );

    // Registered CLA stand-ins: input register then output register.
    logic [4:0] p1 = '0, p2 = '0, q1 = '0, q2 = '0;
    always @(posedge clk) begin
        p1 <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
        p2 <= p1;
        q1 <= {1'b0, s_add_a} + {1'b0, s_add_b} + {4'b0, s_add_cin};
        q2 <= q1;
    end
    assign add_s      = p2[3:0];
    assign add_cout   = p2[4];
    assign s_add_s    = q2[3:0];
    assign s_add_cout = q2[4];

    // Drives one operation from IDLE and checks slice traffic, latency and result; returns with out_valid high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string tag);
        logic [W:0]      full;
        logic [8:0]      exp_slice, got_slice;
        longint unsigned mask, part;
        int              k;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        in_valid = 1'b1; op_a = a; op_b = b; op_cin = c;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept_ready: got %b want 1", tag, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
        for (int cyc = 0; cyc <= L; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (cyc < L && (cyc % (LAT + 1)) == 0) begin
                k    = cyc / (LAT + 1);
                mask = (64'd1 << (4 * k)) - 64'd1;
                part = (64'(a) & mask) + (64'(b) & mask) + 64'(c);
                exp_slice = {4'(a >> (4 * k)), 4'(b >> (4 * k)), 1'(part >> (4 * k))};
                got_slice = {add_a, add_b, add_cin};
                checks++;
                if (got_slice !== exp_slice) begin
                    errors++;
                    $display("FAIL %s slice%0d a/b/cin: got %h/%h/%b want %h/%h/%b", tag, k,
                             add_a, add_b, add_cin, exp_slice[8:5], exp_slice[4:1], exp_slice[0]);
                end
            end
            checks++;
            if (out_valid !== (cyc == L) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s timing cyc%0d: out_valid=%b in_ready=%b want %b/0", tag, cyc,
                         out_valid, in_ready, (cyc == L));
            end
        end
        checks++;
        if (sum !== full[W-1:0] || cout !== full[W]) begin
            errors++;
            $display("FAIL %s result: got %h/%b want %h/%b", tag, sum, cout, full[W-1:0], full[W]);
        end
    endtask

    task automatic finish_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: out_valid=%b in_ready=%b want 0/1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; op_a = 0; op_b = 0; op_cin = 0; out_ready = 0;
        s_in_valid = 0; s_op_a = 0; s_op_b = 0; s_op_cin = 0; s_out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, sum, cout, add_a, add_b, add_cin, in_ready} !== {1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b sum=%h cout=%b add=%h/%h/%b in_ready=%b want 0/0/0/0/0/0/1",
                     out_valid, sum, cout, add_a, add_b, add_cin, in_ready);
        end
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_w4: in_ready=%b out_valid=%b want 1/0", s_in_ready, s_out_valid);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL idle_quiet cyc%0d: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_slices();
        run_op(16'h1999, 16'h1999, 1'b1, "chain1999");
        finish_out("chain1999");
        run_op(16'hFFFF, 16'h0000, 1'b1, "rippleFFFF");
        finish_out("rippleFFFF");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   full;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        run_op(a, b, c, "bp");
        in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== full[W-1:0] || cout !== full[W] || add_a !== 4'h0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: v=%b rdy=%b sum=%h cout=%b add_a=%h want 1/0/%h/%b/0",
                         i, out_valid, in_ready, sum, cout, add_a, full[W-1:0], full[W]);
            end
        end
        in_valid = 1'b0;
        finish_out("bp");
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || add_a !== 4'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_not_taken: in_ready=%b add_a=%h out_valid=%b want 1/0/0", in_ready, add_a, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        in_valid = 1'b1; op_a = 16'h8888; op_b = 16'h8888; op_cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2 * (LAT + 1)) @(posedge clk);
        #1;
        checks++;
        if (add_a !== 4'h8 || add_cin !== 1'b1) begin
            errors++; $display("FAIL abort_at_k2: add_a=%h add_cin=%b want 8/1", add_a, add_cin);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, sum, cout, add_a, add_b, add_cin, in_ready} !== {1'b0, 16'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL abort_clear: out_valid=%b sum=%h cout=%b add=%h/%h/%b in_ready=%b want 0/0/0/0/0/0/1",
                     out_valid, sum, cout, add_a, add_b, add_cin, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * L; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL abort_no_valid cyc%0d: got %b want 0", i, out_valid);
            end
        end
        run_op(16'h0001, 16'h0002, 1'b0, "after_abort");
        finish_out("after_abort");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        run_op(16'h7FFF, 16'h0001, 1'b0, "b2b_first");
        in_valid = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; op_cin = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_a !== 4'h0) begin
            errors++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b add_a=%h want 0/1/0", out_valid, in_ready, add_a);
        end
        out_ready = 1'b1;
        run_op(16'hFFFF, 16'hFFFF, 1'b1, "b2b_second");
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_drain: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         c;
        int           hold;
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; c = 1'b0; end
            run_op(a, b, c, $sformatf("rand%0d", i));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++; $display("FAIL rand%0d_hold: out_valid=%b want 1", i, out_valid);
                end
            end
            finish_out($sformatf("rand%0d", i));
        end
    endtask

    task automatic test_width4();
        logic [3:0] a, b;
        logic       c;
        logic [4:0] full;
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
            if (i == 0) begin a = 4'h9; b = 4'h9; c = 1'b1; end
            full = {1'b0, a} + {1'b0, b} + {4'b0, c};
            s_in_valid = 1'b1; s_op_a = a; s_op_b = b; s_op_cin = c;
            checks++;
            if (s_in_ready !== 1'b1) begin
                errors++; $display("FAIL w4_%0d ready: got %b want 1", i, s_in_ready);
            end
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            checks++;
            if ({s_add_a, s_add_b, s_add_cin} !== {a, b, c}) begin
                errors++; $display("FAIL w4_%0d slice: got %h/%h/%b want %h/%h/%b", i, s_add_a, s_add_b, s_add_cin, a, b, c);
            end
            for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
                @(posedge clk); #1;
                checks++;
                if (s_out_valid !== (cyc == LAT + 1)) begin
                    errors++; $display("FAIL w4_%0d timing cyc%0d: got %b want %b", i, cyc, s_out_valid, (cyc == LAT + 1));
                end
            end
            checks++;
            if (s_sum !== full[3:0] || s_cout !== full[4]) begin
                errors++; $display("FAIL w4_%0d result: got %h/%b want %h/%b", i, s_sum, s_cout, full[3:0], full[4]);
            end
            s_out_ready = 1'b1;
            @(posedge clk); #1;
            s_out_ready = 1'b0;
            checks++;
            if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
                errors++; $display("FAIL w4_%0d handshake: v=%b rdy=%b want 0/1", i, s_out_valid, s_in_ready);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_slices();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
